// File: rtl/pb_event_pkg.sv
// Shared types for the push-button gesture classifier and event scheduler.
package pb_event_pkg;

  localparam int unsigned EVT_W = 2;
  localparam int unsigned GS_W  = 3;

  typedef enum logic [EVT_W-1:0] {
    EVT_NONE   = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_DOUBLE = 2'd3
  } pb_event_t;

  typedef enum logic [GS_W-1:0] {
    GS_IDLE   = 3'd0,
    GS_PRESS1 = 3'd1,
    GS_HOLD   = 3'd2,
    GS_GAP    = 3'd3,
    GS_PRESS2 = 3'd4
  } gesture_state_t;

endpackage

// File: rtl/pb_gesture_fsm.sv
// One button's gesture classifier: turns press/release pulses into SHORT/LONG/DOUBLE strobes.
module pb_gesture_fsm
  import pb_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned DCLICK_CYCLES = 25_000_000,
  parameter int unsigned TMR_WIDTH     =
    $clog2(((LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES) + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pressed,
  input  logic      released,
  output logic      emit_c,
  output pb_event_t code_c
);

  localparam logic [TMR_WIDTH-1:0] TMR_MAX     = '1;
  localparam logic [TMR_WIDTH-1:0] LONG_LAST   = TMR_WIDTH'(LONG_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] DCLICK_LAST = TMR_WIDTH'(DCLICK_CYCLES - 1);

  gesture_state_t        state, state_nxt;
  logic [TMR_WIDTH-1:0]  tmr, tmr_nxt, tmr_inc;

  // Saturating increment so a stuck timer never wraps back to a terminal value.
  assign tmr_inc = (tmr == TMR_MAX) ? tmr : tmr + TMR_WIDTH'(1);

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= GS_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next state, timer and emit strobe; release wins while pressed, press wins while released.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    emit_c    = 1'b0;
    code_c    = EVT_NONE;
    unique case (state)
      GS_IDLE: begin
        if (pressed) begin
          state_nxt = GS_PRESS1;
          tmr_nxt   = '0;
        end
      end
      GS_PRESS1: begin
        if (released) begin
          state_nxt = GS_GAP;
          tmr_nxt   = '0;
        end else if (tmr == LONG_LAST) begin
          state_nxt = GS_HOLD;
          tmr_nxt   = '0;
          emit_c    = 1'b1;
          code_c    = EVT_LONG;
        end else begin
          tmr_nxt   = tmr_inc;
        end
      end
      GS_HOLD: begin
        if (released && !pressed) state_nxt = GS_IDLE;
      end
      GS_GAP: begin
        if (pressed) begin
          state_nxt = GS_PRESS2;
          tmr_nxt   = '0;
        end else if (tmr == DCLICK_LAST) begin
          state_nxt = GS_IDLE;
          tmr_nxt   = '0;
          emit_c    = 1'b1;
          code_c    = EVT_SHORT;
        end else begin
          tmr_nxt   = tmr_inc;
        end
      end
      GS_PRESS2: begin
        if (released) begin
          state_nxt = GS_IDLE;
          emit_c    = 1'b1;
          code_c    = EVT_DOUBLE;
        end
      end
      default: begin
        state_nxt = GS_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pb_event_ctrl.sv
// Gesture classifiers for N buttons, 1-deep per-button event slots and a round-robin
// arbiter feeding a single valid/ready event port.
module pb_event_ctrl
  import pb_event_pkg::*;
#(
  parameter int unsigned N_PB          = 4,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned DCLICK_CYCLES = 25_000_000,
  parameter int unsigned TMR_WIDTH     =
    $clog2(((LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES) + 1),
  parameter int unsigned IDX_WIDTH     = (N_PB > 1) ? $clog2(N_PB) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PB-1:0]      pb_pressed_pulse,
  input  logic [N_PB-1:0]      pb_released_pulse,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EVT_W-1:0]     evt_code,
  output logic [IDX_WIDTH-1:0] evt_btn,
  output logic [N_PB-1:0]      overflow,
  input  logic                 clr_overflow
);

  logic [N_PB-1:0]      emit;
  pb_event_t            fsm_code  [N_PB];
  logic [N_PB-1:0]      pending;
  pb_event_t            slot_code [N_PB];
  logic [N_PB-1:0]      slot_grant;
  logic [IDX_WIDTH-1:0] rr, gnt_idx, rr_nxt;
  logic                 gnt_found;
  logic                 loadable;
  int unsigned          scan;

  // One classifier per button.
  for (genvar g = 0; g < int'(N_PB); g++) begin : g_fsm
    pb_gesture_fsm #(
      .LONG_CYCLES   (LONG_CYCLES),
      .DCLICK_CYCLES (DCLICK_CYCLES),
      .TMR_WIDTH     (TMR_WIDTH)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .pressed  (pb_pressed_pulse[g]),
      .released (pb_released_pulse[g]),
      .emit_c   (emit[g]),
      .code_c   (fsm_code[g])
    );
  end

  assign loadable = !evt_valid || evt_ready;

  // Pick the first pending slot at or after rr, wrapping modulo N_PB.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int unsigned k = 0; k < N_PB; k++) begin
      scan = 32'(rr) + k;
      if (scan >= N_PB) scan = scan - N_PB;
      if (!gnt_found && pending[IDX_WIDTH'(scan)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_WIDTH'(scan);
      end
    end
  end

  // One-hot view of the slot being drained this cycle, plus the rotated pointer.
  always_comb begin
    slot_grant = '0;
    if (loadable && gnt_found) slot_grant[gnt_idx] = 1'b1;
    rr_nxt = (gnt_idx == IDX_WIDTH'(N_PB - 1)) ? '0 : gnt_idx + IDX_WIDTH'(1);
  end

  // Pending slots and sticky overflow; a draining slot can accept a new event in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= '0;
      for (int unsigned i = 0; i < N_PB; i++) slot_code[i] <= EVT_NONE;
    end else begin
      if (clr_overflow) overflow <= '0;
      for (int unsigned i = 0; i < N_PB; i++) begin
        if (emit[i]) begin
          if (pending[i] && !slot_grant[i]) begin
            overflow[i] <= 1'b1;
          end else begin
            pending[i]   <= 1'b1;
            slot_code[i] <= fsm_code[i];
          end
        end else if (slot_grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reload whenever empty or being consumed; code/btn hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
      evt_btn   <= '0;
      rr        <= '0;
    end else if (loadable) begin
      if (gnt_found) begin
        evt_valid <= 1'b1;
        evt_code  <= slot_code[gnt_idx];
        evt_btn   <= gnt_idx;
        rr        <= rr_nxt;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
